// File: rtl/ahb_test_mailbox_mon.sv
// ahb_test_mailbox_mon
//   Passive AHB-Lite write monitor. It snoops one master port and decodes
//   completed writes into:
//     - a pass/fail verdict (MARK_COUNT matching mailbox writes of PASS_CODE
//       or FAIL_CODE),
//     - a character stream (any other mailbox write pushes hwdata[7:0]),
//     - a GPR dump window of DUMP_WORDS 32-bit words.
//   Results are presented on ports so the surrounding bench chooses how to
//   report them.
//
// Ports
//   sysclk, sysrst_b     clock, asynchronous active-low reset
//   mon_htrans/hwrite/hsize/haddr/hwdata/hready   snooped AHB-Lite signals
//   test_pass, test_fail sticky verdict flags
//   test_done            one-cycle pulse when a verdict is first reached
//   chr_valid, chr_data  character FIFO head; chr_ready pops it
//   chr_ovf              sticky: a character was dropped (FIFO full)
//   dump_idx, dump_rdata dump word readback (0 when idx >= DUMP_WORDS)
//   dump_done            sticky: last dump word written
module ahb_test_mailbox_mon #(
   parameter logic [31:0] MBOX_ADDR   = 32'h2000_7C50,
   parameter logic [31:0] PASS_CODE   = 32'h0000_2002,
   parameter logic [31:0] FAIL_CODE   = 32'h0000_1001,
   parameter int unsigned MARK_COUNT  = 2,
   parameter logic [31:0] DUMP_BASE   = 32'h2000_7C60,
   parameter int unsigned DUMP_WORDS  = 16,
   parameter int unsigned CFIFO_DEPTH = 8
) (
   input  logic        sysclk,
   input  logic        sysrst_b,
   input  logic [1:0]  mon_htrans,
   input  logic        mon_hwrite,
   input  logic [2:0]  mon_hsize,
   input  logic [31:0] mon_haddr,
   input  logic [31:0] mon_hwdata,
   input  logic        mon_hready,
   output logic        test_pass,
   output logic        test_fail,
   output logic        test_done,
   output logic        chr_valid,
   output logic [7:0]  chr_data,
   input  logic        chr_ready,
   output logic        chr_ovf,
   input  logic [4:0]  dump_idx,
   output logic [31:0] dump_rdata,
   output logic        dump_done
);

   localparam int unsigned PW        = $clog2(CFIFO_DEPTH);
   localparam logic [31:0] DUMP_SPAN = 4 * DUMP_WORDS;
   localparam logic [PW:0] FIFO_FULL = CFIFO_DEPTH[PW:0];
   localparam logic [PW:0] OCC_ONE   = 1;
   localparam logic [PW-1:0] PTR_ONE = 1;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_PASS,
      ST_FAIL
   } state_t;

   // ------------------------------------------------------------------
   // AHB pipeline: address phase latched, data phase completes on the
   // next cycle with hready high.
   // ------------------------------------------------------------------
   logic        pend_v;
   logic [31:0] pend_addr;
   logic [2:0]  pend_size;
   logic        addr_ok;
   logic        dph_done;

   assign addr_ok  = mon_hready & mon_hwrite &
                     ((mon_htrans == 2'b10) | (mon_htrans == 2'b11));
   assign dph_done = pend_v & mon_hready;

   always_ff @(posedge sysclk or negedge sysrst_b) begin
      if (!sysrst_b) begin
         pend_v    <= 1'b0;
         pend_addr <= '0;
         pend_size <= '0;
      end else if (mon_hready) begin
         // completing data phase and a new address phase share this edge
         pend_v <= addr_ok;
         if (addr_ok) begin
            pend_addr <= mon_haddr;
            pend_size <= mon_hsize;
         end
      end
   end

   // ------------------------------------------------------------------
   // Decode of the completing write
   // ------------------------------------------------------------------
   logic        mbox_hit;
   logic        pass_hit;
   logic        fail_hit;
   logic        chr_push;
   logic [31:0] dump_off;
   logic        dump_hit;
   logic [4:0]  dump_wi;

   assign mbox_hit = dph_done & (pend_addr == MBOX_ADDR);
   assign pass_hit = mbox_hit & (mon_hwdata == PASS_CODE);
   assign fail_hit = mbox_hit & (mon_hwdata == FAIL_CODE);
   assign chr_push = mbox_hit & ~pass_hit & ~fail_hit;

   // addresses below the base wrap to large offsets and miss the window
   assign dump_off = pend_addr - DUMP_BASE;
   assign dump_hit = dph_done & (dump_off < DUMP_SPAN) &
                     (pend_addr[1:0] == 2'b00) & (pend_size == 3'b010);
   assign dump_wi  = dump_off[6:2];

   // ------------------------------------------------------------------
   // Mark counters and verdict FSM
   // ------------------------------------------------------------------
   logic [3:0] pass_cnt;
   logic [3:0] fail_cnt;
   state_t     state;

   always_ff @(posedge sysclk or negedge sysrst_b) begin
      if (!sysrst_b) begin
         pass_cnt <= '0;
         fail_cnt <= '0;
      end else begin
         if (pass_hit && (pass_cnt != 4'hF)) pass_cnt <= pass_cnt + 4'd1;
         if (fail_hit && (fail_cnt != 4'hF)) fail_cnt <= fail_cnt + 4'd1;
      end
   end

   always_ff @(posedge sysclk or negedge sysrst_b) begin
      if (!sysrst_b) begin
         state     <= ST_RUN;
         test_pass <= 1'b0;
         test_fail <= 1'b0;
         test_done <= 1'b0;
      end else begin
         test_done <= 1'b0;
         case (state)
            ST_RUN: begin
               if ({28'd0, pass_cnt} >= MARK_COUNT) begin
                  state     <= ST_PASS;
                  test_pass <= 1'b1;
                  test_done <= 1'b1;
               end else if ({28'd0, fail_cnt} >= MARK_COUNT) begin
                  state     <= ST_FAIL;
                  test_fail <= 1'b1;
                  test_done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Character FIFO
   // ------------------------------------------------------------------
   logic [7:0]    cfifo [CFIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   occ;
   logic          fifo_full;
   logic          chr_pop;
   logic          push_ok;

   assign chr_valid = (occ != '0);
   assign chr_data  = cfifo[rd_ptr];
   assign fifo_full = (occ == FIFO_FULL);
   assign chr_pop   = chr_valid & chr_ready;
   // when full, the slot being written is the head leaving this cycle
   assign push_ok   = chr_push & (~fifo_full | chr_pop);

   always_ff @(posedge sysclk or negedge sysrst_b) begin
      if (!sysrst_b) begin
         for (int unsigned i = 0; i < CFIFO_DEPTH; i++) cfifo[i] <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         occ     <= '0;
         chr_ovf <= 1'b0;
      end else begin
         if (push_ok) begin
            cfifo[wr_ptr] <= mon_hwdata[7:0];
            wr_ptr        <= wr_ptr + PTR_ONE;
         end
         if (chr_pop) rd_ptr <= rd_ptr + PTR_ONE;
         case ({push_ok, chr_pop})
            2'b10:   occ <= occ + OCC_ONE;
            2'b01:   occ <= occ - OCC_ONE;
            default: ;
         endcase
         if (chr_push && fifo_full && !chr_pop) chr_ovf <= 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // GPR dump window
   // ------------------------------------------------------------------
   logic [31:0] dump_mem [DUMP_WORDS];

   always_ff @(posedge sysclk or negedge sysrst_b) begin
      if (!sysrst_b) begin
         for (int unsigned i = 0; i < DUMP_WORDS; i++) dump_mem[i] <= '0;
         dump_done <= 1'b0;
      end else if (dump_hit) begin
         for (int unsigned i = 0; i < DUMP_WORDS; i++) begin
            if ({27'd0, dump_wi} == i) dump_mem[i] <= mon_hwdata;
         end
         if ({27'd0, dump_wi} == DUMP_WORDS - 1) dump_done <= 1'b1;
      end
   end

   always_comb begin
      dump_rdata = '0;
      for (int unsigned i = 0; i < DUMP_WORDS; i++) begin
         if ({27'd0, dump_idx} == i) dump_rdata = dump_mem[i];
      end
   end

endmodule

// File: tb/tb_ahb_test_mailbox_mon.sv
module tb_ahb_test_mailbox_mon;

   localparam logic [31:0] MBOX   = 32'h2000_7C50;
   localparam logic [31:0] PASSC  = 32'h0000_2002;
   localparam logic [31:0] FAILC  = 32'h0000_1001;
   localparam int unsigned MARK   = 2;
   localparam logic [31:0] DBASE  = 32'h2000_7C60;
   localparam int unsigned DWORDS = 16;
   localparam int unsigned DEPTH  = 8;

   logic        sysclk = 1'b0;
   logic        sysrst_b = 1'b0;
   logic [1:0]  mon_htrans = 2'b00;
   logic        mon_hwrite = 1'b0;
   logic [2:0]  mon_hsize = 3'b010;
   logic [31:0] mon_haddr = '0;
   logic [31:0] mon_hwdata = '0;
   logic        mon_hready = 1'b1;
   logic        test_pass, test_fail, test_done;
   logic        chr_valid;
   logic [7:0]  chr_data;
   logic        chr_ready = 1'b0;
   logic        chr_ovf;
   logic [4:0]  dump_idx = '0;
   logic [31:0] dump_rdata;
   logic        dump_done;

   ahb_test_mailbox_mon #(
      .MBOX_ADDR  (MBOX),
      .PASS_CODE  (PASSC),
      .FAIL_CODE  (FAILC),
      .MARK_COUNT (MARK),
      .DUMP_BASE  (DBASE),
      .DUMP_WORDS (DWORDS),
      .CFIFO_DEPTH(DEPTH)
   ) dut (
      .sysclk    (sysclk),
      .sysrst_b  (sysrst_b),
      .mon_htrans(mon_htrans),
      .mon_hwrite(mon_hwrite),
      .mon_hsize (mon_hsize),
      .mon_haddr (mon_haddr),
      .mon_hwdata(mon_hwdata),
      .mon_hready(mon_hready),
      .test_pass (test_pass),
      .test_fail (test_fail),
      .test_done (test_done),
      .chr_valid (chr_valid),
      .chr_data  (chr_data),
      .chr_ready (chr_ready),
      .chr_ovf   (chr_ovf),
      .dump_idx  (dump_idx),
      .dump_rdata(dump_rdata),
      .dump_done (dump_done)
   );

   always #5 sysclk = ~sysclk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [2:0]  size;
      logic [1:0]  trans;
      logic        write;
      int unsigned waits;
   } xfer_t;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   // transaction completing at the next rising edge (set by the driver)
   logic        cmp_v = 1'b0;
   logic [31:0] cmp_addr = '0;
   logic [31:0] cmp_data = '0;
   logic [2:0]  cmp_size = '0;
   int unsigned rdy_pct = 0;

   // reference model state
   int unsigned m_pass = 0, m_fail = 0, m_verdict = 0, m_occ = 0;
   bit          m_done = 0, m_ovf = 0, m_dump_done = 0;
   logic [31:0] m_dump [32];
   logic [7:0]  exp_chr [$];
   bit          s_pop, s_push;
   logic [7:0]  s_ch;
   int unsigned s_wi;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // reference model: transaction-level effects at each rising edge
   initial begin
      for (int i = 0; i < 32; i++) m_dump[i] = '0;
      forever begin
         @(posedge sysclk or negedge sysrst_b);
         if (!sysrst_b) begin
            m_pass = 0; m_fail = 0; m_verdict = 0; m_occ = 0;
            m_done = 0; m_ovf = 0; m_dump_done = 0;
            for (int i = 0; i < 32; i++) m_dump[i] = '0;
            exp_chr.delete();
         end else begin
            // verdict follows the counts as they stood after the previous edge
            m_done = 0;
            if (m_verdict == 0) begin
               if (m_pass >= MARK) begin m_verdict = 1; m_done = 1; end
               else if (m_fail >= MARK) begin m_verdict = 2; m_done = 1; end
            end
            s_pop  = (m_occ != 0) && chr_ready;
            s_push = 0;
            s_ch   = '0;
            if (cmp_v) begin
               if (cmp_addr == MBOX) begin
                  if (cmp_data == PASSC) m_pass++;
                  else if (cmp_data == FAILC) m_fail++;
                  else begin s_push = 1; s_ch = cmp_data[7:0]; end
               end
               if (longint'(cmp_addr) >= longint'(DBASE) &&
                   longint'(cmp_addr) < longint'(DBASE) + 4 * DWORDS &&
                   cmp_addr % 4 == 0 && cmp_size == 3'b010) begin
                  s_wi = (cmp_addr - DBASE) / 4;
                  m_dump[s_wi] = cmp_data;
                  if (s_wi == DWORDS - 1) m_dump_done = 1;
               end
            end
            if (s_pop) m_occ--;
            if (s_push) begin
               if (m_occ < DEPTH) begin exp_chr.push_back(s_ch); m_occ++; end
               else m_ovf = 1;
            end
         end
      end
   end

   // monitor: compares outputs mid-cycle; pops expected characters on handshakes
   initial begin
      forever begin
         @(negedge sysclk);
         #2;
         chk("test_pass", 32'(test_pass), 32'(m_verdict == 1));
         chk("test_fail", 32'(test_fail), 32'(m_verdict == 2));
         chk("test_done", 32'(test_done), 32'(m_done));
         chk("chr_valid", 32'(chr_valid), 32'(m_occ != 0));
         chk("chr_ovf",   32'(chr_ovf),   32'(m_ovf));
         chk("dump_done", 32'(dump_done), 32'(m_dump_done));
         chk("dump_rdata", dump_rdata, (dump_idx < DWORDS) ? m_dump[dump_idx] : 32'h0);
         if (chr_valid && chr_ready) begin
            if (exp_chr.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL chr_data at %0t: popped %h, none expected", $time, chr_data);
            end else begin
               chk("chr_data", 32'(chr_data), 32'(exp_chr.pop_front()));
            end
         end
      end
   end

   // consumer handshake and dump readback index
   initial begin
      forever begin
         @(negedge sysclk);
         chr_ready = ($urandom_range(99) < rdy_pct);
         dump_idx  = dump_idx + 5'd1;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   function automatic xfer_t mk(input logic [31:0] a, input logic [31:0] d,
                                input logic [1:0] tr, input logic [2:0] sz,
                                input int unsigned w);
      xfer_t t;
      t.addr = a; t.data = d; t.trans = tr; t.size = sz; t.write = 1'b1; t.waits = w;
      return t;
   endfunction

   function automatic xfer_t rand_xfer();
      xfer_t t;
      int unsigned r;
      r = $urandom_range(99);
      t.trans = (r < 10) ? 2'b00 : (r < 15) ? 2'b01 : (r < 60) ? 2'b10 : 2'b11;
      t.write = ($urandom_range(9) != 0);
      t.size  = ($urandom_range(4) == 0) ? 3'($urandom_range(2)) : 3'b010;
      t.data  = $urandom;
      r = $urandom_range(9);
      if (r < 4) begin
         t.addr = MBOX;
         r = $urandom_range(9);
         if (r == 0) t.data = PASSC;
         else if (r == 1) t.data = FAILC;
      end else if (r < 8) begin
         t.addr = DBASE + 4 * $urandom_range(DWORDS - 1);
         if ($urandom_range(7) == 0) t.addr = t.addr + 32'($urandom_range(1, 3));
      end else if (r == 8) begin
         t.addr = ($urandom_range(1) == 0) ? DBASE - 4 : DBASE + 4 * DWORDS;
      end else begin
         t.addr = $urandom;
      end
      t.waits = ($urandom_range(3) == 0) ? $urandom_range(1, 3) : 0;
      return t;
   endfunction

   // pipelined driver: cycle k carries address of q[k] and data of q[k-1]
   task automatic run_bus(input xfer_t q[$]);
      for (int unsigned k = 0; k <= q.size(); k++) begin
         if (k < q.size()) begin
            mon_htrans = q[k].trans;
            mon_hwrite = q[k].write;
            mon_haddr  = q[k].addr;
            mon_hsize  = q[k].size;
         end else begin
            mon_htrans = 2'b00;
            mon_hwrite = 1'b0;
         end
         if (k > 0) begin
            for (int unsigned w = 0; w < q[k-1].waits; w++) begin
               mon_hready = 1'b0;
               mon_hwdata = $urandom;
               cmp_v      = 1'b0;
               @(negedge sysclk);
            end
            mon_hwdata = q[k-1].data;
            cmp_v      = q[k-1].write && q[k-1].trans[1];
            cmp_addr   = q[k-1].addr;
            cmp_data   = q[k-1].data;
            cmp_size   = q[k-1].size;
         end else begin
            mon_hwdata = $urandom;
            cmp_v      = 1'b0;
         end
         mon_hready = 1'b1;
         @(negedge sysclk);
      end
      cmp_v = 1'b0;
   endtask

   task automatic idle(input int unsigned n);
      mon_htrans = 2'b00;
      mon_hwrite = 1'b0;
      mon_hready = 1'b1;
      cmp_v      = 1'b0;
      repeat (n) @(negedge sysclk);
   endtask

   task automatic do_reset();
      idle(0);
      sysrst_b = 1'b0;
      repeat (2) @(negedge sysclk);
      sysrst_b = 1'b1;
      @(negedge sysclk);
   endtask

   xfer_t q [$];

   initial begin
      repeat (3) @(negedge sysclk);
      sysrst_b = 1'b1;
      @(negedge sysclk);

      // two zero-wait pass marks
      q = {mk(MBOX, PASSC, 2'b10, 3'b010, 0), mk(MBOX, PASSC, 2'b10, 3'b010, 0)};
      run_bus(q);
      idle(4);

      // fail mark, three wait states, second fail mark
      do_reset();
      q = {mk(MBOX, FAILC, 2'b10, 3'b010, 3), mk(MBOX, FAILC, 2'b10, 3'b010, 0)};
      run_bus(q);
      idle(4);

      // "Hi" held, then drained
      do_reset();
      rdy_pct = 0;
      idle(2);
      q = {mk(MBOX, 32'h48, 2'b10, 3'b000, 0), mk(MBOX, 32'h69, 2'b10, 3'b000, 0)};
      run_bus(q);
      idle(3);
      rdy_pct = 100;
      idle(5);

      // overflow, then push+pop around the full mark
      do_reset();
      rdy_pct = 0;
      idle(2);
      q.delete();
      for (int unsigned i = 0; i <= DEPTH; i++) q.push_back(mk(MBOX, 32'h41 + i, 2'b10, 3'b000, 0));
      run_bus(q);
      idle(2);
      rdy_pct = 50;
      q.delete();
      for (int unsigned i = 0; i < 20; i++) q.push_back(mk(MBOX, 32'h61 + i, 2'b11, 3'b000, 0));
      run_bus(q);
      rdy_pct = 100;
      idle(12);

      // dump window burst, then a byte write to the base
      do_reset();
      q.delete();
      for (int unsigned i = 0; i < DWORDS; i++)
         q.push_back(mk(DBASE + 4 * i, i, (i == 0) ? 2'b10 : 2'b11, 3'b010, 0));
      q.push_back(mk(DBASE, 32'hFFFF_FFFF, 2'b10, 3'b000, 0));
      run_bus(q);
      idle(40);

      // reset between address and data phase of a pass mark
      do_reset();
      q = {mk(MBOX, PASSC, 2'b10, 3'b010, 0)};
      run_bus(q);
      mon_haddr  = MBOX;
      mon_htrans = 2'b10;
      mon_hwrite = 1'b1;
      mon_hsize  = 3'b010;
      mon_hready = 1'b1;
      cmp_v      = 1'b0;
      @(negedge sysclk);
      mon_htrans = 2'b00;
      mon_hwdata = PASSC;
      sysrst_b   = 1'b0;
      repeat (2) @(negedge sysclk);
      sysrst_b   = 1'b1;
      @(negedge sysclk);
      q = {mk(MBOX, PASSC, 2'b10, 3'b010, 0)};
      run_bus(q);
      idle(6);

      // randomized traffic
      for (int unsigned b = 0; b < 60; b++) begin
         if ($urandom_range(2) == 0) do_reset();
         case ($urandom_range(3))
            0: rdy_pct = 0;
            1: rdy_pct = 30;
            2: rdy_pct = 70;
            default: rdy_pct = 100;
         endcase
         q.delete();
         for (int unsigned i = 0; i < $urandom_range(5, 30); i++) q.push_back(rand_xfer());
         run_bus(q);
         idle($urandom_range(0, 3));
      end
      rdy_pct = 100;
      idle(20);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
